dm_access_ctrl: RTL

MEM-stage access controller sitting directly upstream of the 128×32 word-addressed data memory. Takes byte-addressed load/store requests (word, halfword, byte; signed or unsigned loads) from the EX/MEM pipeline register and drives the memory's MemRead/MemWrite/addr/Write_Data. Performs lane extraction and sign extension on loads, and a two-cycle read-modify-write for sub-word stores, stalling the pipeline for one cycle. Detects misaligned accesses and suppresses them.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_lane_unit.sv | 71 +++++++
 rtl/dm_access_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the MEM-stage data-memory access controller:
// access-size encodings, controller state type and data-memory geometry.
// Optional feature macro used by the controller: DM_SUBWORD_EN.
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam int unsigned DM_WORDS  = 128;
   localparam int unsigned DM_ADDR_W = $clog2(DM_WORDS);

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } dm_size_t;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } dm_state_t;

endpackage

// File: rtl/dm_lane_unit.sv
// -----------------------------------------------------------------------------
// dm_lane_unit
// Combinational big-endian lane handling shared by the load and store paths.
// Byte offset 0 is bits [31:24]; halfword offset 0 is bits [31:16].
// Ports:
//   base     in  32  memory word (read data or merge register)
//   size     in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset   in  2   byte offset within the word
//   zero_ext in  1   1 = zero-extend loads, 0 = sign-extend
//   data     in  32  store data, sub-word data in the low bits
//   load     out 32  selected lane, extended to 32 bits
//   merged   out 32  base with the addressed lane replaced by data
// -----------------------------------------------------------------------------
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [31:0] base,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        zero_ext,
   input  logic [31:0] data,
   output logic [31:0] load,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        fill;

   always_comb begin
      byte_lane = '0;
      half_lane = '0;
      fill      = 1'b0;
      load      = base;
      merged    = data;

      case (offset)
         2'd0:    byte_lane = base[31:24];
         2'd1:    byte_lane = base[23:16];
         2'd2:    byte_lane = base[15:8];
         default: byte_lane = base[7:0];
      endcase
      half_lane = offset[1] ? base[15:0] : base[31:16];

      case (size)
         SZ_BYTE: begin
            fill   = ~zero_ext & byte_lane[7];
            load   = {{24{fill}}, byte_lane};
            merged = base;
            case (offset)
               2'd0:    merged[31:24] = data[7:0];
               2'd1:    merged[23:16] = data[7:0];
               2'd2:    merged[15:8]  = data[7:0];
               default: merged[7:0]   = data[7:0];
            endcase
         end
         SZ_HALF: begin
            fill   = ~zero_ext & half_lane[15];
            load   = {{16{fill}}, half_lane};
            merged = base;
            if (offset[1]) merged[15:0]  = data[15:0];
            else           merged[31:16] = data[15:0];
         end
         default: begin
            load   = base;
            merged = data;
         end
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// MEM-stage access controller in front of the word-addressed data memory.
// Handles byte-addressed loads/stores, lane extraction with sign/zero
// extension, misalignment suppression, and a two-cycle read-modify-write for
// sub-word stores (one stall cycle).
// Optional feature: define DM_SUBWORD_EN to enable byte/halfword accesses;
// without it only aligned word accesses are legal and stall is tied low.
// Ports:
//   CLK, RST_N     clock; synchronous active-low reset
//   req_valid      request present
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   loads: 1 = zero-extend
//   req_addr       byte address (ADDR_W+2 bits)
//   req_wdata      store data (sub-word in low bits)
//   stall          upstream hold (high during the RMW write cycle)
//   load_data      registered extended load result
//   load_valid     one-cycle pulse with new load_data
//   align_err      one-cycle registered pulse for misaligned/illegal request
//   mem_read/mem_write/mem_addr/mem_wdata  data-memory controls
//   mem_rdata      data-memory combinational read data
// -----------------------------------------------------------------------------
module dm_access_ctrl
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W = DM_ADDR_W,
   parameter int unsigned DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              align_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic        legal;
   logic        accept;
   logic        idle;
   logic [31:0] lane_base;
   logic [31:0] lane_data;
   logic [1:0]  lane_size;
   logic [1:0]  lane_off;
   logic [31:0] lane_load;
   logic [31:0] lane_merged;

   always_comb begin
      legal = 1'b0;
      case (req_size)
         SZ_WORD: legal = (req_addr[1:0] == 2'b00);
`ifdef DM_SUBWORD_EN
         SZ_HALF: legal = ~req_addr[0];
         SZ_BYTE: legal = 1'b1;
`endif
         default: legal = 1'b0;
      endcase
   end

   assign accept = req_valid & legal;

   dm_lane_unit u_lane (
      .base     (lane_base),
      .size     (lane_size),
      .offset   (lane_off),
      .zero_ext (req_unsigned),
      .data     (lane_data),
      .load     (lane_load),
      .merged   (lane_merged)
   );

`ifdef DM_SUBWORD_EN
   dm_state_t         state_q, state_d;
   logic [31:0]       merge_q;
   logic [31:0]       hold_data;
   logic [ADDR_W-1:0] hold_addr;
   logic [1:0]        hold_size;
   logic [1:0]        hold_off;

   assign idle  = (state_q == IDLE);
   assign stall = (state_q == RMW_WR);

   // The lane unit serves the live request in IDLE and the held store in
   // RMW_WR; the mux lives in its own block so the main decode stays acyclic.
   always_comb begin
      lane_base = mem_rdata;
      lane_size = req_size;
      lane_off  = req_addr[1:0];
      lane_data = req_wdata;
      if (state_q == RMW_WR) begin
         lane_base = merge_q;
         lane_size = hold_size;
         lane_off  = hold_off;
         lane_data = hold_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = req_addr[ADDR_W+1:2];
      mem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!req_write) begin
                  mem_read = 1'b1;
               end else if (req_size == SZ_WORD) begin
                  mem_write = 1'b1;
                  mem_wdata = lane_merged;
               end else begin
                  mem_read = 1'b1;
                  state_d  = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            mem_write = 1'b1;
            mem_addr  = hold_addr;
            mem_wdata = lane_merged;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Gating the strobes with reset abandons an in-flight RMW write.
      if (!RST_N) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         merge_q   <= '0;
         hold_data <= '0;
         hold_addr <= '0;
         hold_size <= '0;
         hold_off  <= '0;
      end else begin
         state_q <= state_d;
         if (idle && accept && req_write && (req_size != SZ_WORD)) begin
            merge_q   <= mem_rdata;
            hold_data <= req_wdata;
            hold_addr <= req_addr[ADDR_W+1:2];
            hold_size <= req_size;
            hold_off  <= req_addr[1:0];
         end
      end
   end
`else
   assign idle  = 1'b1;
   assign stall = 1'b0;

   always_comb begin
      lane_base = mem_rdata;
      lane_size = req_size;
      lane_off  = req_addr[1:0];
      lane_data = req_wdata;
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = req_addr[ADDR_W+1:2];
      mem_wdata = '0;
      if (accept) begin
         if (!req_write) begin
            mem_read = 1'b1;
         end else begin
            mem_write = 1'b1;
            mem_wdata = lane_merged;
         end
      end
      if (!RST_N) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         load_data  <= '0;
         load_valid <= 1'b0;
         align_err  <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         align_err  <= 1'b0;
         if (idle && req_valid) begin
            if (!legal) begin
               align_err <= 1'b1;
            end else if (!req_write) begin
               load_valid <= 1'b1;
               load_data  <= lane_load;
            end
         end
      end
   end

endmodule
